clock_div_bank: RTL and testbench
=================================

Name: clock_div_bank

Overview:
- Parametrised successor to the single clock pass-through wire.
- Generates NUM_CH independent divided clock outputs from one CLK.
- Each channel has a runtime-programmable half-period and a glitch-free divisor update and disable.
- Sits between the top-level clock input and the inline-Verilog submodules that take derived clocks. Each output also has a one-cycle clock-enable tick.

Parameters:
- NUM_CH, 4: number of divided-clock channels (1..16).
- DIV_W, 8: divisor width in bits; half-period range 1..2^DIV_W-1.
- DEFAULT_DIV, 2: half-period loaded into every channel at reset; 0 means the channel resets disabled.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RESETN  input  1  reset, synchronous, active-low.
- cfg_valid  input  1  divisor-update request.
- cfg_ready  output  1  high when the addressed channel can accept an update.
- cfg_chan  input  max(1,clog2(NUM_CH))  target channel index.
- cfg_div  input  DIV_W  new half-period in CLK cycles; 0 disables the channel.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-CLK pulse per channel, coincident with each clk_out rising edge, registered.
- pending  output  NUM_CH  update accepted but not yet applied, per channel.

Behaviour:
- Reset (RESETN low at a CLK edge):
  - clk_out=0, tick=0, pending=0.
  - Per-channel counter cnt=0; active divisor div=DEFAULT_DIV; shadow divisor=0.
  - Reset mid-operation drops any pending update; there is no partial-pulse cleanup (a registered output falls to 0 at that edge).
- Running channel (div!=0):
  - cnt increments each cycle.
  - When cnt==div-1 (the boundary), cnt<=0 and clk_out toggles.
  - Period is 2*div CLK cycles at 50% duty.
  - tick=1 for exactly the cycle in which clk_out goes 0->1, and 0 otherwise.
- Disabled channel (div==0): cnt held 0, clk_out=0, tick=0.
- Handshake:
  - cfg_ready = !pending[cfg_chan] for in-range cfg_chan, and 1 for out-of-range.
  - Transfer occurs when cfg_valid && cfg_ready at a CLK edge.
  - An in-range transfer writes the shadow divisor and sets pending[cfg_chan].
  - An out-of-range transfer is accepted and discarded.
- Apply rules (glitch-free, no runt pulses):
  - Running channel, new value !=0: applied at the next boundary. The new div governs the following phase; cnt restarts at 0. pending clears at that edge.
  - Running channel, new value ==0: applied only at a boundary where clk_out is toggling 1->0. At that edge clk_out falls and the channel stops. If the channel is in its low phase, it completes the low phase, the high phase, then falls and stops.
  - Disabled channel: the new value is applied on the edge after acceptance. pending is high for one cycle. Counting starts from cnt=0 with clk_out=0.
  - Writing the same value as the active div still goes through pending and apply.
- Simultaneous events:
  - A transfer to channel k in the same cycle k applies a previous update is impossible, because cfg_ready is low.
  - Transfers to different channels are independent.
  - Only one transfer per cycle (single config port).
- Width: cnt is DIV_W bits and never exceeds div-1, so there is no wrap-around.
- Latency: with div=d from reset, the first clk_out rise is at the d-th CLK edge after RESETN is first sampled high.

Test Plan:
- Reset with DEFAULT_DIV=2, NUM_CH=4 -> all clk_out rise on edge 2 and fall on edge 4; period 4; tick high on edges 2, 6, 10; pending=0.
- While ch1 is in its high phase at div=2, write cfg_div=5 -> cfg_ready drops for ch1. The phase completes at the old div (falls 2 cycles after rising). The next low phase lasts 5 cycles, then period 10. pending[1] clears at the fall edge.
- Write cfg_div=0 to ch2 during its low phase -> ch2 rises once more, stays high 2 cycles, falls, then clk_out[2]=0 and tick[2]=0 permanently. No pulse shorter than 2 cycles appears.
- With ch2 disabled, write cfg_div=1 -> pending[2] high for 1 cycle; clk_out[2] toggles every cycle (period 2); tick[2] every 2nd cycle.
- Second cfg_valid to ch0 while pending[0]=1 -> cfg_ready=0 and the second request is held off. A concurrent write to ch3 is accepted in the same cycle only if it is presented alone (single port); cfg_chan=5 is accepted with no channel change.
- Assert RESETN low for 1 cycle while ch0 has pending=1 at div=7 -> next edge all outputs 0 and pending cleared. ch0 resumes at DEFAULT_DIV=2, first rise 2 edges after release.

Source files
------------

// File: rtl/clock_div_bank_if.sv
// Divisor-update request port for clock_div_bank.
// One request per cycle; cfg_ready reflects the addressed channel.
interface clock_div_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with
// glitch-free divisor updates and a per-channel rising-edge tick.
module clock_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              CLK,
    input  logic              RESETN,
    clock_div_bank_if.slave   cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);

    logic ready;
    logic xfer;

    // Out-of-range channels match no entry and stay ready.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_chan == CH_W'(i)) begin
                ready = !pending[i];
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign xfer = cfg.cfg_valid && ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] shadow_q;
        logic [DIV_W-1:0] cnt_q;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic             wr;
        logic             at_bnd;

        assign wr     = xfer && (cfg.cfg_chan == CH_W'(g));
        assign at_bnd = (div_q != '0) && (cnt_q == div_q - 1'b1);

        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                div_q    <= DEF;
                shadow_q <= '0;
                cnt_q    <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (div_q == '0) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                    if (pend_q) begin
                        div_q  <= shadow_q;
                        pend_q <= 1'b0;
                    end
                end else if (at_bnd) begin
                    cnt_q <= '0;
                    // A stop request only lands on a falling boundary.
                    if (pend_q && shadow_q == '0 && out_q) begin
                        out_q  <= 1'b0;
                        div_q  <= '0;
                        pend_q <= 1'b0;
                    end else begin
                        out_q  <= !out_q;
                        tick_q <= !out_q;
                        if (pend_q && shadow_q != '0) begin
                            div_q  <= shadow_q;
                            pend_q <= 1'b0;
                        end
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (wr) begin
                    shadow_q <= cfg.cfg_div;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign clk_out[g] = out_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend_q;
    end
endmodule

// File: tb/tb_clock_div_bank.sv
// Directed plus random checks of clock_div_bank against a
// phase-countdown reference model (5 channels so index 5..7 is out of range).
module tb_clock_div_bank;
    localparam int N   = 5;
    localparam int W   = 8;
    localparam int DEF = 2;
    localparam int CW  = 3;

    logic         CLK = 1'b0;
    logic         RESETN;
    logic [N-1:0] clk_out;
    logic [N-1:0] tick;
    logic [N-1:0] pending;

    clock_div_bank_if #(.NUM_CH(N), .DIV_W(W)) cfg ();

    clock_div_bank #(
        .NUM_CH(N),
        .DIV_W(W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .cfg(cfg),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    always #5 CLK = ~CLK;

    // Model: level, edges left in the current phase, active and shadow divisors.
    int m_div [N];
    int m_rem [N];
    int m_sh  [N];
    bit m_lvl [N];
    bit m_tick[N];
    bit m_pend[N];

    int checks = 0;
    int errors = 0;

    function automatic bit exp_ready(int ch);
        if (ch >= N) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic void model_edge(bit v, int ch, int d, bit rn);
        bit ok;
        ok = v && exp_ready(ch);
        if (!rn) begin
            for (int i = 0; i < N; i++) begin
                m_div[i] = DEF; m_rem[i] = DEF; m_sh[i] = 0;
                m_lvl[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            m_tick[i] = 0;
            if (m_div[i] == 0) begin
                m_lvl[i] = 0;
                if (m_pend[i]) begin
                    m_div[i] = m_sh[i];
                    m_rem[i] = m_sh[i];
                    m_pend[i] = 0;
                end
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    if (m_pend[i] && m_sh[i] == 0 && m_lvl[i]) begin
                        m_lvl[i] = 0; m_div[i] = 0; m_pend[i] = 0;
                    end else begin
                        if (m_pend[i] && m_sh[i] != 0) begin
                            m_div[i] = m_sh[i]; m_pend[i] = 0;
                        end
                        m_lvl[i] = !m_lvl[i];
                        m_tick[i] = m_lvl[i];
                        m_rem[i] = m_div[i];
                    end
                end
            end
        end
        if (ok && ch < N) begin
            m_sh[ch] = d;
            m_pend[ch] = 1;
        end
    endfunction

    task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(bit v, int ch, int d, bit rn);
        logic [N-1:0] e_clk, e_tick, e_pend;
        RESETN        = rn;
        cfg.cfg_valid = v;
        cfg.cfg_chan  = CW'(ch);
        cfg.cfg_div   = W'(d);
        #1;
        chk("cfg_ready", N'(cfg.cfg_ready), N'(exp_ready(ch)));
        model_edge(v, ch, d, rn);
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            e_clk[i]  = m_lvl[i];
            e_tick[i] = m_tick[i];
            e_pend[i] = m_pend[i];
        end
        chk("clk_out", clk_out, e_clk);
        chk("tick", tick, e_tick);
        chk("pending", pending, e_pend);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic bound_fail(string tag);
        errors++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    initial begin
        int k;
        RESETN = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_chan = '0;
        cfg.cfg_div = '0;
        @(negedge CLK);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        idle(12);

        // ch1 high phase at div 2 -> reprogram to 5
        k = 0;
        while (!m_lvl[1] && k < 10) begin step(0, 0, 0, 1); k++; end
        if (k == 10) bound_fail("ch1_high");
        step(1, 1, 5, 1);
        idle(25);

        // ch2 low phase -> disable
        k = 0;
        while (m_lvl[2] && k < 10) begin step(0, 0, 0, 1); k++; end
        if (k == 10) bound_fail("ch2_low");
        step(1, 2, 0, 1);
        idle(12);

        // ch2 disabled -> div 1
        step(1, 2, 1, 1);
        idle(8);

        // held-off second request, other channel, out-of-range index
        step(1, 0, 9, 1);
        step(1, 0, 3, 1);
        step(1, 3, 4, 1);
        step(1, 5, 7, 1);
        k = 0;
        while (m_pend[0] && k < 40) begin step(0, 0, 0, 1); k++; end
        if (k == 40) bound_fail("ch0_apply");

        // reset while ch0 pending at div 7
        step(1, 0, 7, 1);
        step(0, 0, 0, 0);
        idle(8);

        for (int i = 0; i < 600; i++) begin
            bit v;
            int ch, d;
            v  = ($urandom_range(0, 2) == 0);
            ch = $urandom_range(0, 7);
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                             : $urandom_range(0, 4);
            step(v, ch, d, $urandom_range(0, 150) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
